// File: rtl/logic_gate_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and the gate block
// under test. The checker owns the master side; whoever hosts the gate
// block (and requests sweeps) sits on the slave side.
interface logic_gate_sweep_checker_if;
  logic       start;
  logic [6:0] gate_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_mask;
  logic [2:0] err_count;
  logic [1:0] first_fail_vec;

  modport master (
    input  start,
    input  gate_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output pass,
    output fail_mask,
    output err_count,
    output first_fail_vec
  );

  modport slave (
    output start,
    output gate_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask,
    input  err_count,
    input  first_fail_vec
  );
endinterface

// File: rtl/logic_gate_sweep_checker.sv
// Sweeps a two-input gate block through {a,b} = 00,01,10,11, holds each
// vector for SETTLE_CYCLES+1 cycles, compares the seven gate outputs with
// the ideal truth table in the last cycle of each dwell and reports the
// per-gate mismatch mask, failing-vector count and first failing vector.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// SETTLE | stimulus applied, counting settle cycles
// CHECK  | gate outputs compared against the expected row
// DONE   | one-cycle completion pulse, stimulus returned to 00
module logic_gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SETTLE_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  logic_gate_sweep_checker_if.master     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [SETTLE_W-1:0] CNT_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [1:0]          vec_q, vec_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [6:0]          fail_mask_q, fail_mask_d;
  logic [2:0]          err_count_q, err_count_d;
  logic [1:0]          first_fail_q, first_fail_d;

  logic [6:0]          expected;
  logic [6:0]          diff;
  logic                mismatch;

  // Ideal outputs for the current vector, bit order {and,or,nand,nor,not a,xor,xnor}
  always_comb begin
    expected = 7'h00;
    case (vec_q)
      2'b00:   expected = 7'h1D;
      2'b01:   expected = 7'h36;
      2'b10:   expected = 7'h32;
      default: expected = 7'h61;
    endcase
  end

  assign diff     = bus.gate_in ^ expected;
  assign mismatch = |diff;

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= 2'b00;
      cnt_q        <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= 7'h00;
      err_count_q  <= 3'd0;
      first_fail_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_mask_q  <= fail_mask_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Next-state and result update logic
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_mask_d  = fail_mask_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_SETTLE;
          vec_d        = 2'b00;
          a_d          = 1'b0;
          b_d          = 1'b0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_mask_d  = 7'h00;
          err_count_d  = 3'd0;
          first_fail_d = 2'b00;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          fail_mask_d = fail_mask_q | diff;
          err_count_d = err_count_q + 3'd1;
          if (err_count_q == 3'd0) begin
            first_fail_d = vec_q;
          end
        end
        if (vec_q == 2'b11) begin
          // Registered outputs must show the verdict in the done cycle itself,
          // so it is resolved on the way into DONE.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 3'd0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d    = S_SETTLE;
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
          cnt_d      = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.a_out          = a_q;
  assign bus.b_out          = b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_mask      = fail_mask_q;
  assign bus.err_count      = err_count_q;
  assign bus.first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_logic_gate_sweep_checker.sv
// Directed bench: a behavioural two-input gate block (with selectable
// faults) sits on the slave side of each checker instance; expected sweep
// results are hand-derived constants.
module tb_logic_gate_sweep_checker;

  logic clk;
  logic rst;
  int   mode1;
  int   mode2;
  int   n_tests;
  int   n_fail;

  logic_gate_sweep_checker_if if1 ();
  logic_gate_sweep_checker_if if2 ();

  logic_gate_sweep_checker #(.SETTLE_CYCLES(2), .SETTLE_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  logic_gate_sweep_checker #(.SETTLE_CYCLES(1), .SETTLE_W(4)) u_dut_s1 (
    .clk (clk),
    .rst (rst),
    .bus (if2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: ideal gates, 1: or stuck at 0, 2: xor/xnor swapped
  function automatic logic [6:0] gate_model(input logic a, input logic b, input int mode);
    logic [6:0] g;
    g = {a & b, a | b, ~(a & b), ~(a | b), ~a, a ^ b, ~(a ^ b)};
    if (mode == 1) g[5] = 1'b0;
    if (mode == 2) g[1:0] = {g[0], g[1]};
    return g;
  endfunction

  assign if1.gate_in = gate_model(if1.a_out, if1.b_out, mode1);
  assign if2.gate_in = gate_model(if2.a_out, if2.b_out, mode2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep on the SETTLE_CYCLES=2 instance; start sampled at edge 0.
  task automatic sweep1(input string tag, input logic [6:0] exp_mask,
                        input logic [2:0] exp_err, input logic [1:0] exp_ffv,
                        input logic exp_pass, input bit repulse);
    int         dones;
    logic [1:0] v;
    dones = 0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if1.start = repulse && (k == 4 || k == 12);
      if (k == 1) begin
        chk({tag, " cleared mask"}, 32'(if1.fail_mask), 32'h0);
        chk({tag, " cleared err"},  32'(if1.err_count), 32'h0);
        chk({tag, " cleared pass"}, 32'(if1.pass), 32'h0);
      end
      if (k <= 12) begin
        v = 2'((k - 1) / 3);
        chk({tag, " ab"},   32'({if1.a_out, if1.b_out}), 32'(v));
        chk({tag, " busy"}, 32'(if1.busy), 32'h1);
        chk({tag, " done early"}, 32'(if1.done), 32'h0);
      end else begin
        chk({tag, " done"}, 32'(if1.done), 32'h1);
        chk({tag, " busy in done"}, 32'(if1.busy), 32'h0);
        chk({tag, " pass at done"}, 32'(if1.pass), 32'(exp_pass));
      end
      if (if1.done) dones++;
      tick();
    end
    if1.start = 1'b0;
    if (if1.done) dones++;
    chk({tag, " done count"}, 32'(dones), 32'd1);
    chk({tag, " pass"},      32'(if1.pass), 32'(exp_pass));
    chk({tag, " fail_mask"}, 32'(if1.fail_mask), 32'(exp_mask));
    chk({tag, " err_count"}, 32'(if1.err_count), 32'(exp_err));
    if (exp_err != 3'd0)
      chk({tag, " first_fail"}, 32'(if1.first_fail_vec), 32'(exp_ffv));
    chk({tag, " ab idle"}, 32'({if1.a_out, if1.b_out}), 32'h0);
    chk({tag, " busy idle"}, 32'(if1.busy), 32'h0);
    tick();
  endtask

  initial begin
    int dones;
    n_tests   = 0;
    n_fail    = 0;
    mode1     = 0;
    mode2     = 0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("reset ab",    32'({if1.a_out, if1.b_out}), 32'h0);
    chk("reset busy",  32'(if1.busy), 32'h0);
    chk("reset done",  32'(if1.done), 32'h0);
    chk("reset pass",  32'(if1.pass), 32'h0);
    chk("reset mask",  32'(if1.fail_mask), 32'h0);
    chk("reset err",   32'(if1.err_count), 32'h0);
    chk("reset ffv",   32'(if1.first_fail_vec), 32'h0);
    chk("reset2 busy", 32'(if2.busy), 32'h0);

    // 1: ideal gates
    mode1 = 0;
    sweep1("ideal", 7'h00, 3'd0, 2'b00, 1'b1, 1'b0);

    // 2: or stuck at 0
    mode1 = 1;
    sweep1("or_stuck", 7'b0100000, 3'd3, 2'b01, 1'b0, 1'b0);

    // 3: xor/xnor swapped
    mode1 = 2;
    sweep1("xor_swap", 7'b0000011, 3'd4, 2'b00, 1'b0, 1'b0);

    // 4: start re-pulsed mid-sweep; fresh results after previous failures
    mode1 = 0;
    sweep1("repulse", 7'h00, 3'd0, 2'b00, 1'b1, 1'b1);

    // 5: reset mid-sweep
    mode1 = 1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    chk("midrst busy before", 32'(if1.busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst ab",   32'({if1.a_out, if1.b_out}), 32'h0);
    chk("midrst busy", 32'(if1.busy), 32'h0);
    chk("midrst done", 32'(if1.done), 32'h0);
    chk("midrst mask", 32'(if1.fail_mask), 32'h0);
    chk("midrst err",  32'(if1.err_count), 32'h0);
    chk("midrst pass", 32'(if1.pass), 32'h0);
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      if (if1.done) dones++;
      tick();
    end
    chk("midrst no done", 32'(dones), 32'd0);
    mode1 = 0;
    sweep1("after_rst", 7'h00, 3'd0, 2'b00, 1'b1, 1'b0);

    // 6: SETTLE_CYCLES=1 instance
    mode2 = 0;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8)
        chk("s1 ab", 32'({if2.a_out, if2.b_out}), 32'((k - 1) / 2));
      chk("s1 done", 32'(if2.done), 32'(k == 9));
      tick();
    end
    chk("s1 pass", 32'(if2.pass), 32'h1);
    chk("s1 mask", 32'(if2.fail_mask), 32'h0);
    chk("s1 err",  32'(if2.err_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_gate_sweep_checker.md
Name: logic_gate_sweep_checker

Overview:
Self-checking stimulus and response stage for the two-input logic gate block. It drives the block's a/b inputs through all four input combinations and waits a programmable settle time per vector. It then samples the seven gate outputs and compares them against the ideal truth table. It reports per-gate failures, an error count, the first failing vector, and pass/fail on a done pulse.

Parameters:
SETTLE_CYCLES, 2, cycles a/b are held before sampling (legal range 1..15); total per-vector dwell is SETTLE_CYCLES+1.
SETTLE_W, 4, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  sweep request; sampled only in IDLE.
gate_in  input  7  DUT outputs: [6]=and, [5]=or, [4]=nand, [3]=nor, [2]=not(a), [1]=xor, [0]=xnor.
a_out  output  1  registered stimulus to DUT input a.
b_out  output  1  registered stimulus to DUT input b.
busy  output  1  high from the cycle after start is accepted through the last CHECK cycle.
done  output  1  single-cycle pulse when the sweep completes.
pass  output  1  1 if the last completed sweep had zero mismatches; held until the next start.
fail_mask  output  7  sticky OR of mismatching gate bits over the sweep, same bit order as gate_in.
err_count  output  3  number of vectors (0..4) with at least one mismatching bit.
first_fail_vec  output  2  index {a,b} of the first failing vector; meaningful only when err_count != 0.

Behaviour:
- Reset: state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, first_fail_vec=0, vector index=0, settle count=0. Reset overrides everything, including mid-sweep; it produces no done pulse.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: on start=1, go to SETTLE. On that same edge: vec=0, {a_out,b_out}=00, settle count=0, busy=1, and fail_mask, err_count, first_fail_vec and pass are all cleared.
- SETTLE: increment the counter. When count==SETTLE_CYCLES-1, go to CHECK.
- CHECK: compare gate_in with expected(vec) combinationally. Expected values by vec {a,b}:
  - 00 -> 7'h1D
  - 01 -> 7'h36
  - 10 -> 7'h32
  - 11 -> 7'h61
- CHECK, on mismatch: diff = gate_in XOR expected. fail_mask |= diff; err_count += 1; if err_count was 0, first_fail_vec = vec.
- CHECK, then: if vec==3, go to DONE with busy=0. Otherwise vec+=1, {a_out,b_out}=new vec, count=0, go to SETTLE.
- DONE: done=1 for exactly this cycle. pass = (err_count==0). {a_out,b_out}=00. Go to IDLE.
- Vector order is 00, 01, 10, 11 ({a,b}). Each vector is stable on a_out/b_out for SETTLE_CYCLES+1 cycles, including the CHECK cycle.
- Latency: if start is sampled at edge 0, done is high in cycle 4*(SETTLE_CYCLES+1)+1. With the default this is cycle 13.
- start while busy or in DONE: ignored. No queuing, no restart.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- err_count saturates naturally at 4; the counter cannot wrap.
- X on gate_in counts as a mismatch for the affected bits. The bench must not drive X in pass scenarios.

Test Plan:
1. Correct gate model connected, SETTLE_CYCLES=2, single start pulse -> a/b sequence 00,01,10,11, each held 3 cycles. done in cycle 13. pass=1, fail_mask=7'h00, err_count=0.
2. or output stuck at 0 -> vectors 01, 10, 11 fail. fail_mask=7'b0100000, err_count=3, first_fail_vec=2'b01, pass=0.
3. xor and xnor outputs swapped -> all vectors fail. fail_mask=7'b0000011, err_count=4, first_fail_vec=2'b00, pass=0.
4. start re-pulsed in cycles 4 and 12 of a sweep -> ignored; exactly one done pulse. A later start clears results, and the second sweep reports fresh values.
5. rst asserted in cycle 5 mid-sweep -> next cycle: all outputs at reset values, no done pulse. A subsequent start runs a full sweep with correct results.
6. SETTLE_CYCLES=1, correct model -> each vector held 2 cycles, done in cycle 9, pass=1.
